// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, runs one req/ack transaction per requested fetch,
// and presents the fetched word with a one-cycle valid pulse. Supports PC redirect and a bus timeout.
module inst_fetch #(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       INST_W   = 18,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              fault_o
);

    localparam int unsigned      CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FAULT
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              discard;
    logic [ADDR_W-1:0] start_addr;

    // A redirect arriving together with a start wins: the fetch goes to the new target.
    assign start_addr = redirect_i ? redirect_pc_i : pc_o;

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc_o         <= RESET_PC;
            imem_addr_o  <= RESET_PC;
            inst_pc_o    <= '0;
            inst_o       <= '0;
            imem_req_o   <= 1'b0;
            inst_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            fault_o      <= 1'b0;
            wait_cnt     <= '0;
            discard      <= 1'b0;
        end else begin
            inst_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start_i) begin
                        imem_addr_o <= start_addr;
                        pc_o        <= start_addr;
                        imem_req_o  <= 1'b1;
                        busy_o      <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= REQ;
                    end else if (redirect_i) begin
                        pc_o <= redirect_pc_i;
                    end
                end
                REQ: begin
                    if (imem_ack_i) begin
                        imem_req_o <= 1'b0;
                        busy_o     <= 1'b0;
                        discard    <= 1'b0;
                        state      <= IDLE;
                        if (redirect_i) begin
                            pc_o <= redirect_pc_i;
                        end else if (!discard) begin
                            inst_o       <= imem_data_i;
                            inst_pc_o    <= imem_addr_o;
                            pc_o         <= imem_addr_o + 1'b1;
                            inst_valid_o <= 1'b1;
                        end
                    end else begin
                        // The bus transaction keeps running; its data is dropped when it lands.
                        if (redirect_i) begin
                            pc_o    <= redirect_pc_i;
                            discard <= 1'b1;
                        end
                        if (TIMEOUT != 0 && wait_cnt == LAST_WAIT) begin
                            fault_o    <= 1'b1;
                            imem_req_o <= 1'b0;
                            busy_o     <= 1'b0;
                            state      <= FAULT;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                FAULT: begin
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed timing sequences, a transaction table,
// randomized transactions against a transaction-level PC/instruction model, and timeout faults.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        redirect = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        ack = 1'b0;
    logic [17:0] data = '0;

    logic        imem_req_o, inst_valid_o, busy_o, fault_o;
    logic [11:0] imem_addr_o, inst_pc_o, pc_o;
    logic [17:0] inst_o;

    logic        to_req, to_valid, to_busy, to_fault;
    logic [11:0] to_addr, to_inst_pc, to_pc;
    logic [17:0] to_inst;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst_n(rst_n), .fetch_start_i(start), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(ack), .imem_data_i(data), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
        .inst_pc_o(inst_pc_o), .pc_o(pc_o), .busy_o(busy_o), .fault_o(fault_o)
    );

    inst_fetch #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .fetch_start_i(start), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(to_req), .imem_addr_o(to_addr),
        .imem_ack_i(ack), .imem_data_i(data), .inst_o(to_inst), .inst_valid_o(to_valid),
        .inst_pc_o(to_inst_pc), .pc_o(to_pc), .busy_o(to_busy), .fault_o(to_fault)
    );

    typedef struct {
        logic        pre;      // redirect alone in IDLE before the start
        logic [11:0] pre_pc;
        logic        co;       // redirect together with the start
        logic [11:0] co_pc;
        int          waits;    // REQ cycles without ack before the ack cycle
        int          mid_at;   // REQ cycle index of a redirect (waits = ack cycle), -1 none
        logic [11:0] mid_pc;
        logic [17:0] data;
    } txn_t;

    typedef struct {
        logic [11:0] addr;
        logic        valid;
        logic [17:0] inst;
        logic [11:0] inst_pc;
        logic [11:0] pc;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    typedef struct {
        logic [11:0] addr;
        logic        stable;
        logic        valid;
        logic [17:0] inst;
        logic [11:0] inst_pc;
        logic [11:0] pc;
        logic        req;
        int          pulses;
    } obs_t;

    // Transaction-level reference state
    logic [11:0] m_pc, m_inst_pc;
    logic [17:0] m_inst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_fetch(input txn_t t, output exp_t e);
        logic [11:0] pc;
        pc = t.pre ? t.pre_pc : m_pc;
        e.addr = t.co ? t.co_pc : pc;
        if (t.mid_at >= 0 && t.mid_at <= t.waits) begin
            e.valid = 1'b0;
            m_pc    = t.mid_pc;
        end else begin
            e.valid   = 1'b1;
            m_inst    = t.data;
            m_inst_pc = e.addr;
            m_pc      = e.addr + 12'd1;
        end
        e.inst    = m_inst;
        e.inst_pc = m_inst_pc;
        e.pc      = m_pc;
    endtask

    task automatic run_txn(input txn_t t, output obs_t o);
        o.stable = 1'b1;
        o.pulses = 0;
        if (t.pre) begin
            redirect = 1'b1; redirect_pc = t.pre_pc;
            step();
            redirect = 1'b0;
        end
        start = 1'b1; redirect = t.co; redirect_pc = t.co_pc;
        step();
        start = 1'b0; redirect = 1'b0;
        o.addr = imem_addr_o;
        for (int i = 0; i <= t.waits; i++) begin
            if (imem_req_o !== 1'b1 || imem_addr_o !== o.addr) o.stable = 1'b0;
            if (inst_valid_o) o.pulses++;
            ack         = (i == t.waits);
            data        = ack ? t.data : 18'($urandom);
            redirect    = (i == t.mid_at);
            redirect_pc = t.mid_pc;
            step();
        end
        ack = 1'b0; redirect = 1'b0;
        o.valid   = inst_valid_o;
        o.inst    = inst_o;
        o.inst_pc = inst_pc_o;
        o.pc      = pc_o;
        o.req     = imem_req_o;
        if (inst_valid_o) o.pulses++;
        step();
        if (inst_valid_o) o.pulses++;
    endtask

    task automatic cmp_txn(input string tag, input exp_t e, input obs_t o);
        check({tag, ".addr"}, 32'(o.addr), 32'(e.addr));
        check({tag, ".addr_stable"}, 32'(o.stable), 32'd1);
        check({tag, ".valid"}, 32'(o.valid), 32'(e.valid));
        check({tag, ".pulses"}, 32'(o.pulses), e.valid ? 32'd1 : 32'd0);
        check({tag, ".inst"}, 32'(o.inst), 32'(e.inst));
        check({tag, ".inst_pc"}, 32'(o.inst_pc), 32'(e.inst_pc));
        check({tag, ".pc"}, 32'(o.pc), 32'(e.pc));
        check({tag, ".req_low"}, 32'(o.req), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        txn_t        t;
        exp_t        e;
        obs_t        o;
        int          to_first, main_first;
        logic [11:0] held_pc;

        // Directed table: {pre, pre_pc, co, co_pc, waits, mid_at, mid_pc, data}, {addr, valid, inst, inst_pc, pc}
        vecs[0] = '{'{1'b0, 12'h000, 1'b0, 12'h000, 3, -1, 12'h000, 18'h01111}, '{12'h000, 1'b1, 18'h01111, 12'h000, 12'h001}};
        vecs[1] = '{'{1'b0, 12'h000, 1'b0, 12'h000, 3, -1, 12'h000, 18'h02222}, '{12'h001, 1'b1, 18'h02222, 12'h001, 12'h002}};
        vecs[2] = '{'{1'b0, 12'h000, 1'b0, 12'h000, 3, -1, 12'h000, 18'h03333}, '{12'h002, 1'b1, 18'h03333, 12'h002, 12'h003}};
        vecs[3] = '{'{1'b1, 12'hFFF, 1'b0, 12'h000, 0, -1, 12'h000, 18'h04444}, '{12'hFFF, 1'b1, 18'h04444, 12'hFFF, 12'h000}};
        vecs[4] = '{'{1'b0, 12'h000, 1'b0, 12'h000, 1, -1, 12'h000, 18'h05555}, '{12'h000, 1'b1, 18'h05555, 12'h000, 12'h001}};
        vecs[5] = '{'{1'b0, 12'h000, 1'b0, 12'h000, 2, 1, 12'h040, 18'h3FFFF}, '{12'h001, 1'b0, 18'h05555, 12'h000, 12'h040}};
        vecs[6] = '{'{1'b0, 12'h000, 1'b0, 12'h000, 0, -1, 12'h000, 18'h06666}, '{12'h040, 1'b1, 18'h06666, 12'h040, 12'h041}};
        vecs[7] = '{'{1'b0, 12'h000, 1'b1, 12'h123, 0, -1, 12'h000, 18'h07777}, '{12'h123, 1'b1, 18'h07777, 12'h123, 12'h124}};
        vecs[8] = '{'{1'b0, 12'h000, 1'b0, 12'h000, 2, 2, 12'h200, 18'h00001}, '{12'h124, 1'b0, 18'h07777, 12'h123, 12'h200}};
        vecs[9] = '{'{1'b0, 12'h000, 1'b0, 12'h000, 0, -1, 12'h000, 18'h00008}, '{12'h200, 1'b1, 18'h00008, 12'h200, 12'h201}};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.req", 32'(imem_req_o), 32'd0);
        check("rst.addr", 32'(imem_addr_o), 32'h000);
        check("rst.pc", 32'(pc_o), 32'h000);
        check("rst.inst", 32'(inst_o), 32'h0);
        check("rst.inst_pc", 32'(inst_pc_o), 32'h000);
        check("rst.valid", 32'(inst_valid_o), 32'd0);
        check("rst.busy", 32'(busy_o), 32'd0);
        check("rst.fault", 32'(fault_o), 32'd0);
        rst_n = 1'b1;

        // Zero-wait fetch: start in cycle 0, req in cycle 1, valid in cycle 2
        start = 1'b1;
        step();
        start = 1'b0;
        check("zw.req", 32'(imem_req_o), 32'd1);
        check("zw.addr", 32'(imem_addr_o), 32'h000);
        check("zw.busy", 32'(busy_o), 32'd1);
        check("zw.valid_early", 32'(inst_valid_o), 32'd0);
        ack = 1'b1; data = 18'h2A5F5;
        step();
        ack = 1'b0;
        check("zw.valid", 32'(inst_valid_o), 32'd1);
        check("zw.inst", 32'(inst_o), 32'h2A5F5);
        check("zw.inst_pc", 32'(inst_pc_o), 32'h000);
        check("zw.pc", 32'(pc_o), 32'h001);
        check("zw.req_drop", 32'(imem_req_o), 32'd0);
        check("zw.busy_drop", 32'(busy_o), 32'd0);
        // Start accepted in the valid cycle
        start = 1'b1;
        step();
        start = 1'b0;
        check("b2b.req", 32'(imem_req_o), 32'd1);
        check("b2b.addr", 32'(imem_addr_o), 32'h001);
        check("b2b.valid_drop", 32'(inst_valid_o), 32'd0);
        ack = 1'b1; data = 18'h0ABCD;
        step();
        ack = 1'b0;
        check("b2b.valid", 32'(inst_valid_o), 32'd1);
        check("b2b.inst", 32'(inst_o), 32'h0ABCD);
        check("b2b.pc", 32'(pc_o), 32'h002);

        // Fresh reset, then the transaction table
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        m_pc = 12'h000; m_inst = '0; m_inst_pc = 12'h000;
        for (int i = 0; i < 10; i++) begin
            model_fetch(vecs[i].t, e);
            run_txn(vecs[i].t, o);
            cmp_txn($sformatf("tab%0d", i), vecs[i].e, o);
        end

        // Randomized transactions against the model
        for (int i = 0; i < 60; i++) begin
            t.pre    = ($urandom_range(0, 3) == 0);
            t.pre_pc = 12'($urandom);
            t.co     = ($urandom_range(0, 3) == 0);
            t.co_pc  = 12'($urandom);
            t.waits  = int'($urandom_range(0, 6));
            t.mid_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, t.waits)) : -1;
            t.mid_pc = 12'($urandom);
            t.data   = 18'($urandom);
            model_fetch(t, e);
            run_txn(t, o);
            cmp_txn($sformatf("rnd%0d", i), e, o);
        end

        // Asynchronous reset mid-REQ
        start = 1'b1;
        step();
        start = 1'b0;
        check("arst.req_before", 32'(imem_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst.req", 32'(imem_req_o), 32'd0);
        check("arst.to_req", 32'(to_req), 32'd0);
        check("arst.busy", 32'(busy_o), 32'd0);
        check("arst.inst", 32'(inst_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ack = 1'b1; data = 18'h15555;
        step();
        ack = 1'b0;
        check("late_ack.valid", 32'(inst_valid_o), 32'd0);
        check("late_ack.inst", 32'(inst_o), 32'h0);
        check("late_ack.req", 32'(imem_req_o), 32'd0);

        // Timeout: TIMEOUT=4 instance faults after 4 REQ cycles, default after 16
        start = 1'b1;
        step();
        start = 1'b0;
        to_first = 0; main_first = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (to_fault && to_first == 0) begin
                to_first = cyc;
                check("to4.req_drop", 32'(to_req), 32'd0);
                check("to4.busy_drop", 32'(to_busy), 32'd0);
                check("to16.not_yet", 32'(fault_o), 32'd0);
                check("to16.req_held", 32'(imem_req_o), 32'd1);
            end
            if (fault_o && main_first == 0) begin
                main_first = cyc;
                check("to16.req_drop", 32'(imem_req_o), 32'd0);
            end
            if (to_first != 0 && main_first != 0) break;
            start = cyc[0];
            step();
        end
        start = 1'b0;
        check("to4.fault_cycle", 32'(to_first), 32'd5);
        check("to16.fault_cycle", 32'(main_first), 32'd17);

        // FAULT ignores everything
        held_pc = pc_o;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; ack = 1'b1; redirect = 1'b1;
            redirect_pc = 12'($urandom); data = 18'($urandom);
            step();
            check("flt.fault", 32'(fault_o), 32'd1);
            check("flt.to_fault", 32'(to_fault), 32'd1);
            check("flt.req", 32'(imem_req_o), 32'd0);
            check("flt.valid", 32'(inst_valid_o), 32'd0);
            check("flt.pc", 32'(pc_o), 32'(held_pc));
        end
        start = 1'b0; ack = 1'b0; redirect = 1'b0;

        // Only reset clears the fault
        rst_n = 1'b0;
        #1;
        check("clr.fault", 32'(fault_o), 32'd0);
        check("clr.to_fault", 32'(to_fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("clr.restart_req", 32'(to_req), 32'd1);
        check("clr.restart_addr", 32'(imem_addr_o), 32'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
